// File: rtl/disp7seg_scan_if.sv
// Signal bundle between the display-driving logic (master) and the
// seven-segment scanner (slave). Names are from the scanner's point of view.
interface disp7seg_scan_if #(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned BRIGHT_W   = 4
);
  logic [4*NUM_DIGITS-1:0] i_digits;
  logic [NUM_DIGITS-1:0]   i_dp_en;
  logic [NUM_DIGITS-1:0]   i_blank;
  logic [NUM_DIGITS-1:0]   i_glyph_en;
  logic [7*NUM_DIGITS-1:0] i_glyph;
  logic                    i_lz_en;
  logic [BRIGHT_W-1:0]     i_brightness;
  logic [7:0]              o_seg;
  logic [NUM_DIGITS-1:0]   o_an;
  logic                    o_frame_start;

  modport master (
    output i_digits, i_dp_en, i_blank, i_glyph_en, i_glyph, i_lz_en, i_brightness,
    input  o_seg, o_an, o_frame_start
  );

  modport slave (
    input  i_digits, i_dp_en, i_blank, i_glyph_en, i_glyph, i_lz_en, i_brightness,
    output o_seg, o_an, o_frame_start
  );
endinterface

// File: rtl/disp7seg_scan.sv
// Time-multiplexed seven-segment scanner: NUM_DIGITS hex digits on one shared
// active-low segment bus, with blanking, glyphs, zero suppression and PWM dimming.
module disp7seg_scan #(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned DIV        = 2500,
  parameter int unsigned BRIGHT_W   = 4
) (
  input logic            clk,
  input logic            rst_n,
  disp7seg_scan_if.slave bus
);
  localparam int unsigned PW = $clog2(DIV);
  localparam int unsigned IW = $clog2(NUM_DIGITS);

  logic [PW-1:0]         r_presc;
  logic [IW-1:0]         r_idx;
  logic [BRIGHT_W-1:0]   r_pwm;
  logic [7:0]            r_seg;
  logic [NUM_DIGITS-1:0] r_an;
  logic                  r_frame_start;

  logic                  w_tick;
  logic                  w_last;
  logic                  w_run;
  logic [NUM_DIGITS-1:0] w_supp;
  logic [3:0]            w_nib;
  logic [6:0]            w_glyph;
  logic                  w_glyph_en;
  logic                  w_dp;
  logic                  w_blank;
  logic                  w_sup_cur;
  logic                  w_vis;
  logic [6:0]            w_segs;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  assign w_tick = (r_presc == PW'(DIV - 1));
  assign w_last = (r_idx == IW'(NUM_DIGITS - 1));

  // Suppression walks from the most significant digit down; the run of
  // plain zeros breaks at the first non-zero value or glyph digit.
  always_comb begin
    w_run  = 1'b1;
    w_supp = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      w_run = w_run && (bus.i_digits[4*(NUM_DIGITS-1-k) +: 4] == 4'h0)
                    && !bus.i_glyph_en[NUM_DIGITS-1-k];
      w_supp[NUM_DIGITS-1-k] = bus.i_lz_en && w_run && (k != NUM_DIGITS - 1);
    end
  end

  always_comb begin
    w_nib      = '0;
    w_glyph    = '1;
    w_glyph_en = 1'b0;
    w_dp       = 1'b0;
    w_blank    = 1'b0;
    w_sup_cur  = 1'b0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (r_idx == IW'(k)) begin
        w_nib      = bus.i_digits[4*k +: 4];
        w_glyph    = bus.i_glyph[7*k +: 7];
        w_glyph_en = bus.i_glyph_en[k];
        w_dp       = bus.i_dp_en[k];
        w_blank    = bus.i_blank[k];
        w_sup_cur  = w_supp[k];
      end
    end
  end

  assign w_segs = w_glyph_en ? w_glyph : hex7(w_nib);
  // presc==0 is the dead cycle that separates adjacent digits.
  assign w_vis  = !w_blank && !w_sup_cur && (r_pwm < bus.i_brightness) && (r_presc != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc       <= '0;
      r_idx         <= '0;
      r_pwm         <= '0;
      r_seg         <= '1;
      r_an          <= '1;
      r_frame_start <= 1'b0;
    end else begin
      r_presc       <= w_tick ? '0 : r_presc + PW'(1);
      if (w_tick) r_idx <= w_last ? '0 : r_idx + IW'(1);
      r_pwm         <= r_pwm + BRIGHT_W'(1);
      r_frame_start <= w_tick && w_last;
      r_an          <= w_vis ? ~(NUM_DIGITS'(1) << r_idx) : '1;
      r_seg         <= w_vis ? {~w_dp, w_segs} : '1;
    end
  end

  assign bus.o_seg         = r_seg;
  assign bus.o_an          = r_an;
  assign bus.o_frame_start = r_frame_start;
endmodule

// File: tb/tb_disp7seg_scan.sv
// Bench for disp7seg_scan: vector table checked cycle-by-cycle via a scoreboard
// queue, plus hand-written duty-count and mid-slot reset sequences.
module tb_disp7seg_scan;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  disp7seg_scan_if #(.NUM_DIGITS(8), .BRIGHT_W(4)) bus4 ();
  disp7seg_scan_if #(.NUM_DIGITS(8), .BRIGHT_W(4)) bus64 ();

  disp7seg_scan #(.NUM_DIGITS(8), .DIV(4), .BRIGHT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4.slave));
  disp7seg_scan #(.NUM_DIGITS(8), .DIV(64), .BRIGHT_W(4)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .bus(bus64.slave));

  typedef struct packed {
    logic        sel64;
    logic [31:0] digits;
    logic [7:0]  dp_en;
    logic [7:0]  blank;
    logic [7:0]  glyph_en;
    logic [55:0] glyph;
    logic        lz_en;
    logic [3:0]  bright;
    logic [7:0]  lit;    // digits expected to light (before PWM/dead gating)
    logic [63:0] segs;   // expected seg byte per digit, digit i at [8i+:8]
  } vec_t;

  typedef struct packed {
    logic [7:0] an;
    logic [7:0] seg;
    logic       fs;
  } exp_t;

  vec_t vecs[11];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %02h expected %02h at %0t", name, act, req, $time);
  endtask

  task automatic drive(input vec_t v);
    bus4.i_digits = v.digits;     bus64.i_digits = v.digits;
    bus4.i_dp_en = v.dp_en;       bus64.i_dp_en = v.dp_en;
    bus4.i_blank = v.blank;       bus64.i_blank = v.blank;
    bus4.i_glyph_en = v.glyph_en; bus64.i_glyph_en = v.glyph_en;
    bus4.i_glyph = v.glyph;       bus64.i_glyph = v.glyph;
    bus4.i_lz_en = v.lz_en;       bus64.i_lz_en = v.lz_en;
    bus4.i_brightness = v.bright; bus64.i_brightness = v.bright;
  endtask

  task automatic reset_and_start(input vec_t v);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_an", bus4.o_an, 8'hFF);
    check("rst_seg", bus4.o_seg, 8'hFF);
    check("rst_fs", {7'd0, bus4.o_frame_start}, 8'h00);
    drive(v);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Timing model: after the k-th rising edge since release, outputs reflect
  // the state after k-1 edges: presc=m%DIV, idx=(m/DIV)%8, pwm=m%16.
  task automatic run_vec(input vec_t v, input int ncyc);
    int   div;
    int   m, presc, idx, pwm;
    logic vis;
    exp_t e, got;
    div = v.sel64 ? 64 : 4;
    reset_and_start(v);
    for (int k = 1; k <= ncyc; k++) begin
      m     = k - 1;
      presc = m % div;
      idx   = (m / div) % 8;
      pwm   = m % 16;
      vis   = v.lit[idx] && (presc != 0) && (pwm < int'(v.bright));
      e.an  = vis ? ~(8'h01 << idx) : 8'hFF;
      e.seg = vis ? v.segs[8*idx +: 8] : 8'hFF;
      e.fs  = (k % (div * 8)) == 0;
      sb.push_back(e);
      @(posedge clk);
      #1;
      got = v.sel64 ? {bus64.o_an, bus64.o_seg, bus64.o_frame_start}
                    : {bus4.o_an, bus4.o_seg, bus4.o_frame_start};
      e = sb.pop_front();
      check("an", got.an, e.an);
      check("seg", got.seg, e.seg);
      check("frame_start", {7'd0, got.fs}, {7'd0, e.fs});
    end
  endtask

  initial begin : main
    vec_t base;
    int   lows, others;
    base = '0;
    base.digits = 32'h76543210;
    base.bright = 4'hF;
    base.lit    = 8'hFF;
    base.segs   = 64'hF8829299B0A4F9C0;
    drive(base);

    vecs[0] = base;
    vecs[1] = base; vecs[1].lz_en = 1'b1; vecs[1].digits = 32'h00000A05;
    vecs[1].lit = 8'h07; vecs[1].segs = 64'hFFFFFFFFFF88C092;
    vecs[2] = base; vecs[2].lz_en = 1'b1; vecs[2].digits = 32'h0;
    vecs[2].lit = 8'h01; vecs[2].segs = 64'hFFFFFFFFFFFFFFC0;
    vecs[3] = vecs[2]; vecs[3].dp_en = 8'h01; vecs[3].segs = 64'hFFFFFFFFFFFFFF40;
    vecs[4] = vecs[2]; vecs[4].glyph_en = 8'h80; vecs[4].glyph = 56'h12000000000000;
    vecs[4].lit = 8'hFF; vecs[4].segs = 64'h89C0C0C0C0C0C0C0;
    vecs[5] = base; vecs[5].blank = 8'h20; vecs[5].lit = 8'hDF;
    vecs[6] = base; vecs[6].digits = 32'hFEDCBA98; vecs[6].dp_en = 8'h05;
    vecs[6].segs = 64'h8E86A1C683089000;
    vecs[7] = base; vecs[7].bright = 4'h0;
    vecs[8] = vecs[2]; vecs[8].glyph_en = 8'h04; vecs[8].glyph = 56'h1E4000;
    vecs[8].lit = 8'h07; vecs[8].segs = 64'hFFFFFFFFFFF9C0C0;
    vecs[9] = base; vecs[9].bright = 4'h7;
    vecs[10] = base; vecs[10].sel64 = 1'b1; vecs[10].bright = 4'h4;

    for (int unsigned i = 0; i < 11; i++)
      run_vec(vecs[i], vecs[i].sel64 ? 192 : 64);

    // Digit-0 slot at DIV=64, brightness 4: 15 lit cycles out of 63 non-dead.
    reset_and_start(vecs[10]);
    lows = 0;
    others = 0;
    for (int k = 1; k <= 64; k++) begin
      @(posedge clk);
      #1;
      if (bus64.o_an[0] == 1'b0) lows++;
      if (bus64.o_an[7:1] != 7'h7F) others++;
    end
    check("duty_low_count", 8'(lows), 8'd15);
    check("duty_other_anodes", 8'(others), 8'd0);

    // Mid-slot reset while digit 5 is lit, then scanning restarts at digit 0.
    reset_and_start(base);
    repeat (22) @(posedge clk);
    #1;
    check("pre_rst_an", bus4.o_an, 8'hDF);
    check("pre_rst_seg", bus4.o_seg, 8'h92);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_an", bus4.o_an, 8'hFF);
    check("midrst_seg", bus4.o_seg, 8'hFF);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_dead_an", bus4.o_an, 8'hFF);
    @(posedge clk);
    #1;
    check("post_rst_first_an", bus4.o_an, 8'hFE);
    check("post_rst_first_seg", bus4.o_seg, 8'hC0);
    check("post_rst_fs", {7'd0, bus4.o_frame_start}, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
